seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder_pkg.sv | 11 +
 rtl/rca_segment.sv | 27 ++
 rtl/seg_pipe_adder.sv | 147 ++++++++++++++
 tb/tb_seg_pipe_adder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pipe_adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package seg_pipe_adder_pkg;

    localparam int WIDTH_DEF = 24;
    localparam int SEG_W_DEF = 8;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational ripple-carry adder for one pipeline segment of W bits.
module rca_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    // NOTE: combinational logic uses blocking '=' so each bit sees the carry computed just before it.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[W];

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined adder: one SEG_W-bit ripple segment per stage, valid/ready with global stall.
// Optional signed-overflow output enabled by defining SEG_PIPE_ADDER_OVF_EN.
module seg_pipe_adder
    import seg_pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry_in,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_valid,
`ifdef SEG_PIPE_ADDER_OVF_EN
    output logic             o_overflow,
`endif
    input  logic             i_ready
);

    localparam int STAGES = ceil_div(WIDTH, SEG_W);
    localparam int LAST   = STAGES - 1;

    // Stage registers (output side of stage k).
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];

    // Stage inputs and the values each stage would register next.
    logic             stg_v [STAGES];
    logic [WIDTH-1:0] stg_a [STAGES];
    logic [WIDTH-1:0] stg_b [STAGES];
    logic [WIDTH-1:0] stg_s [STAGES];
    logic             stg_c [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];

    // The whole pipe moves together; it freezes only while the output is blocked.
    logic advance;

    assign o_valid  = vld_q[LAST];
    assign o_result = {c_q[LAST], s_q[LAST]};
    assign o_ready  = !(o_valid && !i_ready);
    assign advance  = o_ready;

    always_comb begin
        stg_v[0] = i_valid;
        stg_a[0] = i_add_term1;
        stg_b[0] = i_add_term2;
        stg_s[0] = '0;
        stg_c[0] = i_carry_in;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k] = vld_q[k - 1];
            stg_a[k] = a_q[k - 1];
            stg_b[k] = b_q[k - 1];
            stg_s[k] = s_q[k - 1];
            stg_c[k] = c_q[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        localparam int W  = (k == LAST) ? (WIDTH - LO) : SEG_W;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({W{1'b1}}) << LO;

        logic [W-1:0] seg_sum;
        logic         seg_cout;

        rca_segment #(.W(W)) u_seg (
            .a    (stg_a[k][LO +: W]),
            .b    (stg_b[k][LO +: W]),
            .cin  (stg_c[k]),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        assign nxt_s[k] = (stg_s[k] & ~MASK) | (WIDTH'(seg_sum) << LO);
        assign nxt_c[k] = seg_cout;
    end

    // NOTE: every output is given its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        if (advance) begin
            vld_d = stg_v;
            a_d   = stg_a;
            b_d   = stg_b;
            s_d   = nxt_s;
            c_d   = nxt_c;
        end
    end

    // NOTE: data registers are reset too, because o_result is observable and must read 0 after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
        end
    end

`ifdef SEG_PIPE_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    always_comb begin
        ovf_d = ovf_q;
        if (advance) begin
            ovf_d = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1]
                  ^ nxt_s[LAST][WIDTH-1] ^ nxt_c[LAST];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed and randomized checks for seg_pipe_adder at 24/8 and 20/8 configurations.
module tb_seg_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_n;

    logic [23:0] a1, b1;
    logic        c1, v1, rdy_in1, rdy_out1, ov1;
    logic [24:0] res1;

    logic [19:0] a2, b2;
    logic        c2, v2, rdy_in2, rdy_out2, ov2;
    logic [20:0] res2;

`ifdef SEG_PIPE_ADDER_OVF_EN
    logic ovf1, ovf2;
`endif

    seg_pipe_adder #(.WIDTH(24), .SEG_W(8)) u_dut24 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_add_term1 (a1),
        .i_add_term2 (b1),
        .i_carry_in  (c1),
        .i_valid     (v1),
        .o_ready     (rdy_out1),
        .o_result    (res1),
        .o_valid     (ov1),
`ifdef SEG_PIPE_ADDER_OVF_EN
        .o_overflow  (ovf1),
`endif
        .i_ready     (rdy_in1)
    );

    seg_pipe_adder #(.WIDTH(20), .SEG_W(8)) u_dut20 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_add_term1 (a2),
        .i_add_term2 (b2),
        .i_carry_in  (c2),
        .i_valid     (v2),
        .o_ready     (rdy_out2),
        .o_result    (res2),
        .o_valid     (ov2),
`ifdef SEG_PIPE_ADDER_OVF_EN
        .o_overflow  (ovf2),
`endif
        .i_ready     (rdy_in2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v1 = 1'b0;
        rdy_in1 = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 24'h123456; b1 = 24'h000001; c1 = 1'b0; v1 = 1'b1; rdy_in1 = 1'b0;
        tick();
        tick();
        checks++;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ov1); end
        checks++;
        if (res1 !== 25'h0) begin errors++; $display("FAIL reset_result got=%h want=0", res1); end
        checks++;
        if (rdy_out1 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", rdy_out1); end
        rst_n = 1'b1;
        v1 = 1'b0;
        rdy_in1 = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (ov1 === 1'b1) seen++;
            end
            checks++;
            if (seen != 0) begin errors++; $display("FAIL reset_no_accept got=%0d want=0", seen); end
        end
        checks++;
        if (rdy_out1 !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b want=1", rdy_out1); end
    endtask

    task automatic test_latency();
        int n;
        a1 = 24'hFFFFFF; b1 = 24'h000001; c1 = 1'b0; v1 = 1'b1; rdy_in1 = 1'b1;
        tick();
        v1 = 1'b0;
        n = 1;
        while (ov1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL latency got=%0d want=3", n); end
        checks++;
        if (res1 !== 25'h1000000) begin errors++; $display("FAIL latency_sum got=%h want=1000000", res1); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [23:0] ta [4] = '{24'h000001, 24'h000003, 24'h800000, 24'h000000};
        logic [23:0] tb [4] = '{24'h000002, 24'h000004, 24'h800000, 24'h000000};
        logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [24:0] exp_r [4] = '{25'h3, 25'h7, 25'h1000000, 25'h1};
        logic [24:0] got [8];
        int          at  [8];
        int          n = 0;
        rdy_in1 = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 4) begin
                a1 = ta[cyc]; b1 = tb[cyc]; c1 = tc[cyc]; v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            tick();
            if (ov1 === 1'b1 && n < 8) begin
                got[n] = res1;
                at[n]  = cyc;
                n++;
            end
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (got[i] !== exp_r[i] || at[i] != 2 + i) begin
                errors++;
                $display("FAIL b2b_result%0d got=%h@%0d want=%h@%0d", i, got[i], at[i], exp_r[i], 2 + i);
            end
        end
        idle(2);
    endtask

    task automatic test_stall();
        logic [23:0] ta [3] = '{24'h000010, 24'hABCDEF, 24'hFFFFFF};
        logic [23:0] tb [3] = '{24'h000020, 24'h111111, 24'hFFFFFF};
        logic        tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [24:0] exp_r [3] = '{25'h30, 25'hBCDF00, 25'h1FFFFFF};
        logic [24:0] held;
        logic [24:0] got [6];
        int          n = 0;
        int          bad = 0;
        rdy_in1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a1 = ta[i]; b1 = tb[i]; c1 = tc[i]; v1 = 1'b1;
            tick();
        end
        a1 = 24'h00000F; b1 = 24'h00000F; c1 = 1'b0; v1 = 1'b1;
        rdy_in1 = 1'b0;
        #1;
        checks++;
        if (rdy_out1 !== 1'b0 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready got=%b/%b want=0/1", rdy_out1, ov1);
        end
        held = res1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ov1 !== 1'b1 || res1 !== held || rdy_out1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles want=0", bad); end
        v1 = 1'b0;
        rdy_in1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ov1 === 1'b1) begin
                got[n] = res1;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL stall_drain_count got=%0d want=3", n); end
        for (int i = 0; i < 3 && i < n; i++) begin
            checks++;
            if (got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL stall_drain%0d got=%h want=%h", i, got[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rdy_in1 = 1'b1;
        a1 = 24'h000100; b1 = 24'h000200; c1 = 1'b0; v1 = 1'b1;
        tick();
        a1 = 24'h000300; b1 = 24'h000400; c1 = 1'b1;
        tick();
        rst_n = 1'b0;
        a1 = 24'h000500; b1 = 24'h000600; c1 = 1'b0;
        tick();
        checks++;
        if (ov1 !== 1'b0 || res1 !== 25'h0) begin
            errors++;
            $display("FAIL midreset_clear got=%b/%h want=0/0", ov1, res1);
        end
        checks++;
        if (rdy_out1 !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b want=1", rdy_out1); end
        rst_n = 1'b1;
        v1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov1 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_stale got=%0d want=0", seen); end
    endtask

`ifdef SEG_PIPE_ADDER_OVF_EN
    task automatic run_op1(input logic [23:0] a, input logic [23:0] b, output logic [24:0] r,
                           output logic o, output logic ok);
        int n = 0;
        a1 = a; b1 = b; c1 = 1'b0; v1 = 1'b1; rdy_in1 = 1'b1;
        tick();
        v1 = 1'b0;
        while (ov1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (ov1 === 1'b1);
        r  = res1;
        o  = ovf1;
        idle(2);
    endtask

    task automatic test_overflow();
        logic [24:0] r;
        logic        o, ok;
        run_op1(24'h7FFFFF, 24'h000001, r, o, ok);
        checks++;
        if (!ok || o !== 1'b1 || r !== 25'h0800000) begin
            errors++;
            $display("FAIL ovf_pos got=%b/%h want=1/0800000", o, r);
        end
        run_op1(24'hFFFFFF, 24'h000001, r, o, ok);
        checks++;
        if (!ok || o !== 1'b0 || r !== 25'h1000000) begin
            errors++;
            $display("FAIL ovf_wrap got=%b/%h want=0/1000000", o, r);
        end
    endtask
`endif

    task automatic test_w20();
        int          n;
        int          sent = 0;
        int          cyc = 0;
        logic [20:0] q[$];
        logic [20:0] exp_r;
        logic        prev_stall = 1'b0;
        logic [20:0] prev_res = '0;

        a2 = 20'hFFFFF; b2 = 20'h00001; c2 = 1'b0; v2 = 1'b1; rdy_in2 = 1'b1;
        tick();
        v2 = 1'b0;
        n = 1;
        while (ov2 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3 || res2 !== 21'h100000) begin
            errors++;
            $display("FAIL w20_edge got=%h@%0d want=100000@3", res2, n);
        end
        tick();
        tick();

        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            v2      = (sent < 10000) && ($urandom_range(0, 3) != 0);
            rdy_in2 = ($urandom_range(0, 3) != 0);
            a2      = 20'($urandom);
            b2      = 20'($urandom);
            c2      = 1'($urandom);
            #1;
            if (prev_stall) begin
                checks++;
                if (ov2 !== 1'b1 || res2 !== prev_res) begin
                    errors++;
                    $display("FAIL w20_stall_hold got=%b/%h want=1/%h", ov2, res2, prev_res);
                end
            end
            if (v2 && rdy_out2 === 1'b1) begin
                q.push_back(21'(a2) + 21'(b2) + 21'(c2));
                sent++;
            end
            if (ov2 === 1'b1 && rdy_in2) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL w20_spurious got=%h want=none", res2);
                end else begin
                    exp_r = q.pop_front();
                    if (res2 !== exp_r) begin
                        errors++;
                        $display("FAIL w20_random got=%h want=%h", res2, exp_r);
                    end
                end
            end
            prev_stall = (ov2 === 1'b1) && !rdy_in2;
            prev_res   = res2;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (sent != 10000 || q.size() != 0) begin
            errors++;
            $display("FAIL w20_drain got=%0d sent %0d pending want=10000 sent 0 pending", sent, q.size());
        end
        v2 = 1'b0;
        rdy_in2 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0; v1 = 1'b0; rdy_in1 = 1'b1;
        a2 = '0; b2 = '0; c2 = 1'b0; v2 = 1'b0; rdy_in2 = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef SEG_PIPE_ADDER_OVF_EN
        test_overflow();
`endif
        test_w20();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
